pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the En and flush (sync-clear Rst)
//  inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  Resolves load-use hazards, taken branches, multi-cycle EX ops and external memory stalls.
//  Holds a multi-cycle-op FSM.
// PARAMETERS
//  RW      5   register-index width
//  MC_LAT  4   EX occupancy of a multi-cycle op, in cycles; must be >= 2
//  CW      $clog2(MC_LAT)  latency-counter width
// PORTS
//  Clk          in   1    clock, rising edge
//  Rst          in   1    reset, asynchronous, active-low
//  ID_Rs        in   RW   source reg 1 of instruction in ID
//  ID_Rt        in   RW   source reg 2 of instruction in ID
//  ID_UsesRt    in   1    ID instruction reads Rt
//  EX_MemRead   in   1    EX instruction is a load
//  EX_Rd        in   RW   destination reg of EX instruction
//  EX_BrTaken   in   1    branch resolved taken in EX
//  EX_McStart   in   1    EX instruction is a multi-cycle op
//  Ext_Stall    in   1    memory not ready: freeze pipeline
//  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En   out  1 each   register enables
//  IFID_Flush, IDEX_Flush, EXMEM_Flush           out  1 each   register sync clears (bubble insert)
//  StallCnt     out  32   stall-cycle count (feature-gated)
//  FlushCnt     out  32   flush-event count (feature-gated)
// BEHAVIOUR
//  State: RUN, MC_BUSY. Counter cnt[CW-1:0]. Rst low: state=RUN, cnt=0, all En=0, all Flush=1.
//  Outputs are combinational from state + inputs, so there is zero-cycle latency.
//  Priority, highest first: Ext_Stall > multi-cycle > branch > load-use > normal.
//  Ext_Stall=1: all En=0, all Flush=0; state and cnt hold.
//  RUN & EX_McStart: PC/IFID/IDEX En=0, EXMEM_Flush=1, MEMWB_En=1; cnt<=MC_LAT-2; next=MC_BUSY.
//  MC_BUSY & cnt!=0: same stall outputs; cnt<=cnt-1.
//  MC_BUSY & cnt==0: release cycle. All En=1, no flush, next=RUN.
//   EX_McStart is ignored in MC_BUSY, including in the release cycle.
//   Total stall cycles per op = MC_LAT-1.
//  RUN & EX_BrTaken: all En=1, IFID_Flush=1, IDEX_Flush=1 (PC loads target).
//  RUN & load-use: condition is EX_MemRead & EX_Rd!=0 & (EX_Rd==ID_Rs | (ID_UsesRt & EX_Rd==ID_Rt)).
//   Response: PC_En=0, IFID_En=0, IDEX_Flush=1, EXMEM/MEMWB En=1. Single cycle, no state change.
//  Branch + load-use in the same cycle: branch wins, the wrong-path instruction is squashed.
//  EX_McStart & EX_BrTaken together: protocol violation. Flag it with a simulation assertion;
//   the multi-cycle op wins.
//  Normal: all En=1, all Flush=0.
//  Rst asserted mid-MC_BUSY: immediate return to RUN; the op is discarded.
// CONFIGURATION
//  Macro PIPE_HAZARD_PERF_EN.
//  Defined: StallCnt increments on every cycle with PC_En=0 while Rst is high.
//   FlushCnt increments on every cycle with IFID_Flush|IDEX_Flush|EXMEM_Flush while Rst is high.
//   Both counters wrap at 2^32 and clear on reset.
//  Undefined: StallCnt=FlushCnt=0 constant, no counter flops; ports remain.
// STRUCTURE
//  Package pipe_ctrl_pkg holds:
//   state enum {RUN, MC_BUSY}
//   REG_ZERO constant
//   en/flush bundle struct, shared with the pipeline top
//  Sub-module mc_latency_cnt: load/decrement/zero-detect counter. Inputs load, dec, hold;
//   output zero.
// TESTING
//  1 Reset: hold Rst low 3 cycles.
//    -> all En=0, all Flush=1; after release, state RUN and all En=1.
//  2 Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs=5.
//    -> one cycle of PC_En=IFID_En=0 with IDEX_Flush=1. Repeat with EX_Rd=0 -> no stall.
//  3 Multi-cycle, MC_LAT=4: EX_McStart held 4 cycles.
//    -> 3 stall cycles (EXMEM_Flush=1), 4th cycle all En=1, then RUN.
//    Ext_Stall pulsed mid-op -> stall extended by the pulse length, cnt preserved.
//  4 Branch + load-use in the same cycle.
//    -> IFID_Flush=IDEX_Flush=1, PC_En=1, no load stall.
//  5 Rst low during MC_BUSY (cnt=1) -> RUN on release, no residual stall.
//  6 PIPE_HAZARD_PERF_EN defined: run scenarios 2+3 -> StallCnt=4, FlushCnt=4.
//    Macro undefined -> both counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, control bundle and constants.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } hz_ctl_t;

  // Enables (PC..MEMWB) then flushes (IFID..EXMEM); flushing stages keep En=1 so the clear lands
  localparam hz_ctl_t CTL_NORMAL  = 8'b11111_000;
  localparam hz_ctl_t CTL_RESET   = 8'b00000_111;
  localparam hz_ctl_t CTL_FREEZE  = 8'b00000_000;
  localparam hz_ctl_t CTL_MC      = 8'b00011_001;
  localparam hz_ctl_t CTL_BRANCH  = 8'b11111_110;
  localparam hz_ctl_t CTL_LOADUSE = 8'b00111_010;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and stall/flush controls back to the pipeline registers.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned RW = 5
);
  logic [RW-1:0] ID_Rs;
  logic [RW-1:0] ID_Rt;
  logic          ID_UsesRt;
  logic          EX_MemRead;
  logic [RW-1:0] EX_Rd;
  logic          EX_BrTaken;
  logic          EX_McStart;
  logic          Ext_Stall;
  logic          PC_En;
  logic          IFID_En;
  logic          IDEX_En;
  logic          EXMEM_En;
  logic          MEMWB_En;
  logic          IFID_Flush;
  logic          IDEX_Flush;
  logic          EXMEM_Flush;
  logic [31:0]   StallCnt;
  logic [31:0]   FlushCnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rd, EX_BrTaken, EX_McStart, Ext_Stall,
    input  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rd, EX_BrTaken, EX_McStart, Ext_Stall,
    output PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_chk.sv
// Protocol checker: a multi-cycle op and a taken branch must never be presented together.
module pipeline_hazard_ctrl_chk (
  input logic Clk,
  input logic Rst,
  input logic EX_McStart,
  input logic EX_BrTaken
);

  mc_branch_excl_a: assert property (@(posedge Clk) disable iff (!Rst)
    !(EX_McStart && EX_BrTaken));

endmodule

// File: rtl/pipeline_hazard_ctrl_mc_latency_cnt.sv
// Multi-cycle op latency counter: load to MC_LAT-2, count down, freeze on hold, flag zero.
module mc_latency_cnt #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CW     = $clog2(MC_LAT)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  input  logic dec,
  input  logic hold,
  output logic zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LAT - 2);

  logic [CW-1:0] cnt_q;

  // Counter register; hold wins over decrement so an external freeze preserves the count
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= {CW{1'b0}};
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (hold) begin
      cnt_q <= cnt_q;
    end else if (dec) begin
      cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; controls are combinational (zero latency).
// Optional perf counters StallCnt/FlushCnt are built only when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RW     = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CW     = $clog2(MC_LAT)
) (
  input logic                  Clk,
  input logic                  Rst,
  pipeline_hazard_ctrl_if.slave hz
);

  hz_state_e state_q, state_d;
  hz_ctl_t   ctl_s;
  logic      load_s, dec_s, zero_s, load_use_s;

  assign load_use_s = hz.EX_MemRead && (hz.EX_Rd != RW'(REG_ZERO)) &&
                      ((hz.EX_Rd == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_Rd == hz.ID_Rt)));

  // Priority resolution: external stall > multi-cycle > branch > load-use > normal
  always_comb begin
    ctl_s   = CTL_NORMAL;
    state_d = state_q;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    if (!Rst) begin
      ctl_s = CTL_RESET;
    end else if (hz.Ext_Stall) begin
      ctl_s = CTL_FREEZE;
    end else begin
      case (state_q)
        MC_BUSY: begin
          if (!zero_s) begin
            ctl_s = CTL_MC;
            dec_s = 1'b1;
          end else begin
            ctl_s   = CTL_NORMAL;
            state_d = RUN;
          end
        end
        RUN: begin
          if (hz.EX_McStart) begin
            ctl_s   = CTL_MC;
            load_s  = 1'b1;
            state_d = MC_BUSY;
          end else if (hz.EX_BrTaken) begin
            ctl_s = CTL_BRANCH;
          end else if (load_use_s) begin
            ctl_s = CTL_LOADUSE;
          end else begin
            ctl_s = CTL_NORMAL;
          end
        end
        default: begin
          ctl_s   = CTL_NORMAL;
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM state register; reset mid-op discards the op
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  mc_latency_cnt #(.MC_LAT(MC_LAT), .CW(CW)) u_mc_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (load_s),
    .dec  (dec_s),
    .hold (hz.Ext_Stall),
    .zero (zero_s)
  );

  pipeline_hazard_ctrl_chk u_chk (
    .Clk        (Clk),
    .Rst        (Rst),
    .EX_McStart (hz.EX_McStart),
    .EX_BrTaken (hz.EX_BrTaken)
  );

  assign hz.PC_En       = ctl_s.pc_en;
  assign hz.IFID_En     = ctl_s.ifid_en;
  assign hz.IDEX_En     = ctl_s.idex_en;
  assign hz.EXMEM_En    = ctl_s.exmem_en;
  assign hz.MEMWB_En    = ctl_s.memwb_en;
  assign hz.IFID_Flush  = ctl_s.ifid_flush;
  assign hz.IDEX_Flush  = ctl_s.idex_flush;
  assign hz.EXMEM_Flush = ctl_s.exmem_flush;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Performance counters, free-running and wrapping at 2^32
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!ctl_s.pc_en) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ctl_s.ifid_flush || ctl_s.idex_flush || ctl_s.exmem_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = 32'd0;
  assign hz.FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues hand-computed controls, monitor compares at negedge.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] N  = 8'b11111_000;
  localparam logic [7:0] R  = 8'b00000_111;
  localparam logic [7:0] LU = 8'b00111_010;
  localparam logic [7:0] MC = 8'b00011_001;
  localparam logic [7:0] BR = 8'b11111_110;
  localparam logic [7:0] EX = 8'b00000_000;
`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [31:0] C1 = 32'd1;
  localparam logic [31:0] C4 = 32'd4;
`else
  localparam logic [31:0] C1 = 32'd0;
  localparam logic [31:0] C4 = 32'd0;
`endif

  typedef struct {
    logic [7:0]  ctl;
    bit          chk_cnt;
    logic [31:0] sc;
    logic [31:0] fc;
    int          id;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  exp_t e;
  int   checks;
  int   errors;
  int   step_id;
  logic [7:0] act;

  pipeline_hazard_ctrl_if #(.RW(5)) hz();

  pipeline_hazard_ctrl #(.RW(5), .MC_LAT(4)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic ext, input logic mc, input logic br,
                      input logic mr, input logic [4:0] exrd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic usert, input logic [7:0] exp_ctl,
                      input bit chk, input logic [31:0] sc, input logic [31:0] fc);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n         = rst;
    hz.Ext_Stall  = ext;
    hz.EX_McStart = mc;
    hz.EX_BrTaken = br;
    hz.EX_MemRead = mr;
    hz.EX_Rd      = exrd;
    hz.ID_Rs      = rs;
    hz.ID_Rt      = rt;
    hz.ID_UsesRt  = usert;
    step_id       = step_id + 1;
    x.ctl = exp_ctl;
    x.chk_cnt = chk;
    x.sc = sc;
    x.fc = fc;
    x.id = step_id;
    q.push_back(x);
  endtask

  task automatic idle(input logic [7:0] exp_ctl);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, exp_ctl, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: compare whatever the controller presents against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {hz.PC_En, hz.IFID_En, hz.IDEX_En, hz.EXMEM_En, hz.MEMWB_En,
             hz.IFID_Flush, hz.IDEX_Flush, hz.EXMEM_Flush};
      checks = checks + 1;
      if (act !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL ctl step %0d: got %b expected %b", e.id, act, e.ctl);
      end
      if (e.chk_cnt) begin
        checks = checks + 2;
        if (hz.StallCnt !== e.sc) begin
          errors = errors + 1;
          $display("FAIL stallcnt step %0d: got %0d expected %0d", e.id, hz.StallCnt, e.sc);
        end
        if (hz.FlushCnt !== e.fc) begin
          errors = errors + 1;
          $display("FAIL flushcnt step %0d: got %0d expected %0d", e.id, hz.FlushCnt, e.fc);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; step_id = 0;
    rst_n = 1'b0;
    hz.Ext_Stall = 1'b0; hz.EX_McStart = 1'b0; hz.EX_BrTaken = 1'b0; hz.EX_MemRead = 1'b0;
    hz.EX_Rd = 5'd0; hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_UsesRt = 1'b0;

    // Reset held three cycles, then release
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, R, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b1, 32'd0, 32'd0);

    // Load-use on Rs, then EX_Rd=0 must not stall
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, LU, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b1, C1, C1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b0, 32'd0, 32'd0);

    // Multi-cycle op with EX_McStart held 4 cycles: 3 stalls then release
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MC, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b1, C4, C4);

    // Ext_Stall pulsed for 2 cycles mid-op: stall extends, count preserved
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MC, 1'b0, 32'd0, 32'd0);
    idle(MC);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, EX, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, EX, 1'b0, 32'd0, 32'd0);
    idle(MC);
    idle(N);
    idle(N);

    // Branch + load-use together: branch wins; branch alone; Ext_Stall over branch
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, BR, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, BR, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, EX, 1'b0, 32'd0, 32'd0);

    // Load-use through Rt only when ID_UsesRt is set
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, LU, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, N, 1'b0, 32'd0, 32'd0);

    // Reset during MC_BUSY with cnt=1: op discarded, no residual stall
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MC, 1'b0, 32'd0, 32'd0);
    idle(MC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, R, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, R, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, N, 1'b1, 32'd0, 32'd0);
    idle(N);
    idle(N);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
